// File: rtl/mem_ctrl.sv
// Byte-wide RAM/IO controller: arbitrates the D-cache write stream, D-cache reads and I-cache fetches,
// and assembles multi-byte little-endian reads with sign/zero extension.
module mem_ctrl #(
  parameter int ADDR_W    = 32,
  parameter int IO_SEL_HI = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              d_read_i,
  input  logic              d_sign_i,
  input  logic [2:0]        d_len_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  output logic [31:0]       d_data_o,
  output logic              d_done_o,
  output logic              d_wait_o,
  input  logic              d_write_i,
  input  logic [ADDR_W-1:0] d_waddr_i,
  input  logic [7:0]        d_wdata_i,
  output logic              d_wwait_o,
  output logic              d_writting_o,
  input  logic              i_read_i,
  input  logic [ADDR_W-1:0] i_addr_i,
  output logic [31:0]       i_data_o,
  output logic              i_done_o,
  output logic              i_wait_o,
  input  logic [7:0]        mem_din_i,
  output logic [7:0]        mem_dout_o,
  output logic [ADDR_W-1:0] mem_a_o,
  output logic              mem_wr_o,
  input  logic              io_buffer_full_i
);

  typedef enum logic {IDLE, READ} state_t;

  state_t            state;
  logic              own_i;
  logic [ADDR_W-1:0] base;
  logic [2:0]        len;
  logic              sign;
  logic [2:0]        k;
  logic [1:0]        r;
  logic              rcv;
  logic [3:0][7:0]   rbuf;

  logic              is_io, d_acc, i_acc, last;
  logic [2:0]        req_len;
  logic [3:0][7:0]   asm_b;
  logic [31:0]       word;

  assign is_io = (d_waddr_i[IO_SEL_HI:IO_SEL_HI-1] == 2'b11);

  always_comb begin
    d_wwait_o    = (state != IDLE) || (is_io && io_buffer_full_i);
    d_writting_o = d_write_i && !d_wwait_o;
    d_wait_o     = (state != IDLE) || d_writting_o;
    i_wait_o     = (state != IDLE) || d_writting_o || d_read_i;
    d_acc        = d_read_i && !d_wait_o;
    i_acc        = i_read_i && !i_wait_o;
  end

  // Anything other than 1 or 2 is read as a full word.
  always_comb begin
    req_len = 3'd4;
    if (d_len_i == 3'd1) req_len = 3'd1;
    if (d_len_i == 3'd2) req_len = 3'd2;
  end

  // Fold the byte arriving this cycle into the assembly so completion needs no extra cycle.
  always_comb begin
    asm_b    = rbuf;
    asm_b[r] = mem_din_i;
    last     = ({1'b0, r} == len - 3'd1);
    case (len)
      3'd1:    word = {{24{sign & asm_b[0][7]}}, asm_b[0]};
      3'd2:    word = {{16{sign & asm_b[1][7]}}, asm_b[1], asm_b[0]};
      default: word = asm_b;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      own_i      <= 1'b0;
      base       <= '0;
      len        <= '0;
      sign       <= 1'b0;
      k          <= '0;
      r          <= '0;
      rcv        <= 1'b0;
      rbuf       <= '0;
      mem_a_o    <= '0;
      mem_dout_o <= '0;
      mem_wr_o   <= 1'b0;
      d_data_o   <= '0;
      i_data_o   <= '0;
      d_done_o   <= 1'b0;
      i_done_o   <= 1'b0;
    end else begin
      d_done_o <= 1'b0;
      i_done_o <= 1'b0;
      mem_wr_o <= 1'b0;
      case (state)
        IDLE: begin
          if (d_writting_o) begin
            mem_a_o    <= d_waddr_i;
            mem_dout_o <= d_wdata_i;
            mem_wr_o   <= 1'b1;
          end else if (d_acc || i_acc) begin
            own_i   <= !d_acc;
            base    <= d_acc ? d_addr_i : i_addr_i;
            mem_a_o <= d_acc ? d_addr_i : i_addr_i;
            len     <= d_acc ? req_len : 3'd4;
            sign    <= d_acc && d_sign_i;
            k       <= 3'd1;
            r       <= '0;
            rcv     <= 1'b0;
            rbuf    <= '0;
            state   <= READ;
          end
        end
        READ: begin
          if (k < len) begin
            mem_a_o <= base + {{(ADDR_W-3){1'b0}}, k};
            k       <= k + 3'd1;
          end
          // First READ cycle carries no data yet: RAM answers one cycle after the address.
          if (!rcv) begin
            rcv <= 1'b1;
          end else begin
            rbuf <= asm_b;
            if (last) begin
              state <= IDLE;
              if (own_i) begin
                i_data_o <= word;
                i_done_o <= 1'b1;
              end else begin
                d_data_o <= word;
                d_done_o <= 1'b1;
              end
            end else begin
              r <= r + 2'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: byte RAM model, per-owner scoreboards with data and done-cycle checks.
module tb_mem_ctrl;
  logic        clk, rst;
  logic        d_read_i, d_sign_i, d_write_i, i_read_i, io_buffer_full_i;
  logic [2:0]  d_len_i;
  logic [31:0] d_addr_i, d_waddr_i, i_addr_i, mem_a_o, d_data_o, i_data_o;
  logic [7:0]  d_wdata_i, mem_din_i, mem_dout_o;
  logic        d_done_o, d_wait_o, d_wwait_o, d_writting_o, i_done_o, i_wait_o, mem_wr_o;

  mem_ctrl #(.ADDR_W(32), .IO_SEL_HI(17)) dut (
    .clk(clk), .rst(rst),
    .d_read_i(d_read_i), .d_sign_i(d_sign_i), .d_len_i(d_len_i), .d_addr_i(d_addr_i),
    .d_data_o(d_data_o), .d_done_o(d_done_o), .d_wait_o(d_wait_o),
    .d_write_i(d_write_i), .d_waddr_i(d_waddr_i), .d_wdata_i(d_wdata_i),
    .d_wwait_o(d_wwait_o), .d_writting_o(d_writting_o),
    .i_read_i(i_read_i), .i_addr_i(i_addr_i), .i_data_o(i_data_o), .i_done_o(i_done_o),
    .i_wait_o(i_wait_o), .mem_din_i(mem_din_i), .mem_dout_o(mem_dout_o), .mem_a_o(mem_a_o),
    .mem_wr_o(mem_wr_o), .io_buffer_full_i(io_buffer_full_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] data; int cyc; } exp_t;
  exp_t dq[$];
  exp_t iq[$];

  int n_chk = 0, n_pass = 0, cyc = 0, d_cnt = 0;
  logic [7:0]  ram [0:262143];
  logic [31:0] alog [0:4095];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  // RAM: registered read, write takes effect on the edge ending the write cycle.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_wr_o) ram[mem_a_o[17:0]] <= mem_dout_o;
    mem_din_i <= ram[mem_a_o[17:0]];
  end

  always @(negedge clk) begin
    alog[cyc % 4096] <= mem_a_o;
    if (!rst && d_done_o) begin
      d_cnt <= d_cnt + 1;
      if (dq.size() == 0) chk("d_spurious_done", 32'd1, 32'd0);
      else begin
        chk("d_data", d_data_o, dq[0].data);
        chk("d_done_cycle", cyc, dq[0].cyc);
        void'(dq.pop_front());
      end
    end
    if (!rst && i_done_o) begin
      chk("i_ddone_quiet", {31'd0, d_done_o}, 32'd0);
      if (iq.size() == 0) chk("i_spurious_done", 32'd1, 32'd0);
      else begin
        chk("i_data", i_data_o, iq[0].data);
        chk("i_done_cycle", cyc, iq[0].cyc);
        void'(iq.pop_front());
      end
    end
  end

  task automatic dwrite(input logic [31:0] a, input logic [7:0] d);
    bit ok = 0;
    @(posedge clk); #1;
    d_write_i = 1'b1; d_waddr_i = a; d_wdata_i = d;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (d_writting_o) begin ok = 1; break; end
    end
    if (!ok) chk("wr_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    d_write_i = 1'b0;
  endtask

  task automatic drain();
    bit ok = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk); #1;
      if (dq.size() == 0 && iq.size() == 0) begin ok = 1; break; end
    end
    if (!ok) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic dread(input logic own, input logic [31:0] a, input logic [2:0] len,
                       input logic s, input logic [31:0] exp, output int t);
    int lat;
    lat = (len == 3'd1) ? 3 : (len == 3'd2) ? 4 : 6;
    @(posedge clk); #1;
    if (own) begin i_read_i = 1'b1; i_addr_i = a; end
    else begin d_read_i = 1'b1; d_addr_i = a; d_len_i = len; d_sign_i = s; end
    t = -1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (!(own ? i_wait_o : d_wait_o)) begin t = cyc; break; end
    end
    if (t < 0) chk("acc_timeout", 32'd0, 32'd1);
    else if (own) iq.push_back('{exp, t + lat});
    else dq.push_back('{exp, t + lat});
    @(posedge clk); #1;
    d_read_i = 1'b0; i_read_i = 1'b0;
    drain();
  endtask

  logic [31:0] wa [13] = '{32'h100, 32'h101, 32'h102, 32'h103, 32'h20, 32'h41, 32'h42,
                           32'h200, 32'h201, 32'h202, 32'h203, 32'hFFFF_FFFF, 32'h0};
  logic [7:0]  wd [13] = '{8'h13, 8'h05, 8'h00, 8'h00, 8'h80, 8'h34, 8'hF2,
                           8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h11, 8'h22};

  initial begin
    int t, td, c0;
    bit ok;
    rst = 1'b1; d_read_i = 0; d_sign_i = 0; d_len_i = 0; d_addr_i = 0; d_write_i = 0;
    d_waddr_i = 0; d_wdata_i = 0; i_read_i = 0; i_addr_i = 0; io_buffer_full_i = 0;
    #12;
    chk("rst_mem_a", mem_a_o, 32'd0);
    chk("rst_mem_wr", {31'd0, mem_wr_o}, 32'd0);
    chk("rst_mem_dout", {24'd0, mem_dout_o}, 32'd0);
    chk("rst_d_done", {31'd0, d_done_o}, 32'd0);
    chk("rst_i_done", {31'd0, i_done_o}, 32'd0);
    chk("rst_d_data", d_data_o, 32'd0);
    chk("rst_i_data", i_data_o, 32'd0);
    @(posedge clk); #1; rst = 1'b0;

    for (int i = 0; i < 13; i++) dwrite(wa[i], wd[i]);

    dread(1'b1, 32'h100, 3'd4, 1'b0, 32'h0000_0513, t);
    dread(1'b0, 32'h20, 3'd1, 1'b1, 32'hFFFF_FF80, t);
    dread(1'b0, 32'h20, 3'd1, 1'b0, 32'h0000_0080, t);
    dread(1'b0, 32'h41, 3'd2, 1'b1, 32'hFFFF_F234, t);
    chk("hw_addr0", alog[(t + 1) % 4096], 32'h41);
    chk("hw_addr1", alog[(t + 2) % 4096], 32'h42);
    dread(1'b0, 32'h41, 3'd2, 1'b0, 32'h0000_F234, t);
    dread(1'b0, 32'h200, 3'd3, 1'b1, 32'hDEAD_BEEF, t);
    dread(1'b0, 32'hFFFF_FFFF, 3'd2, 1'b0, 32'h0000_2211, t);
    chk("wrap_addr", alog[(t + 2) % 4096], 32'h0);

    // Arbitration: all three requesters at once.
    @(posedge clk); #1;
    d_write_i = 1; d_waddr_i = 32'h300; d_wdata_i = 8'h55;
    d_read_i = 1; d_addr_i = 32'h20; d_len_i = 3'd1; d_sign_i = 1;
    i_read_i = 1; i_addr_i = 32'h100;
    @(negedge clk);
    chk("arb_writting", {31'd0, d_writting_o}, 32'd1);
    chk("arb_d_wait", {31'd0, d_wait_o}, 32'd1);
    chk("arb_i_wait", {31'd0, i_wait_o}, 32'd1);
    @(posedge clk); #1; d_write_i = 0;
    @(negedge clk);
    chk("arb_d_acc", {31'd0, d_wait_o}, 32'd0);
    chk("arb_i_held", {31'd0, i_wait_o}, 32'd1);
    td = cyc;
    dq.push_back('{32'hFFFF_FF80, td + 3});
    @(posedge clk); #1; d_read_i = 0;
    ok = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (!i_wait_o) begin ok = 1; break; end
    end
    chk("arb_i_acc_cycle", ok ? cyc : -1, td + 3);
    iq.push_back('{32'h0000_0513, cyc + 6});
    @(posedge clk); #1; i_read_i = 0;
    drain();

    // IO write stream stalled by a full UART buffer.
    io_buffer_full_i = 1;
    @(posedge clk); #1;
    d_write_i = 1; d_waddr_i = 32'h30000; d_wdata_i = 8'hA0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk("stall_writting", {31'd0, d_writting_o}, 32'd0);
      chk("stall_mem_wr", {31'd0, mem_wr_o}, 32'd0);
    end
    @(posedge clk); #1; io_buffer_full_i = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i < 4) chk("stream_writting", {31'd0, d_writting_o}, 32'd1);
      if (i > 0) begin
        chk("stream_addr", mem_a_o, 32'h30000 + i - 1);
        chk("stream_wr", {31'd0, mem_wr_o}, 32'd1);
      end
      @(posedge clk); #1;
      if (i < 3) begin d_waddr_i = 32'h30000 + i + 1; d_wdata_i = 8'hA1 + i[7:0]; end
      else d_write_i = 0;
    end
    dread(1'b0, 32'h30000, 3'd4, 1'b0, 32'hA3A2_A1A0, t);

    // Reset in the second cycle of a word read.
    @(posedge clk); #1;
    d_read_i = 1; d_addr_i = 32'h200; d_len_i = 3'd4; d_sign_i = 0;
    ok = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (!d_wait_o) begin ok = 1; break; end
    end
    if (!ok) chk("rst_acc_timeout", 32'd0, 32'd1);
    @(posedge clk); #1; d_read_i = 0;
    @(posedge clk); #2;
    c0 = d_cnt;
    rst = 1;
    #1;
    chk("midrst_d_data", d_data_o, 32'd0);
    chk("midrst_mem_a", mem_a_o, 32'd0);
    chk("midrst_d_done", {31'd0, d_done_o}, 32'd0);
    repeat (2) @(posedge clk);
    #1; rst = 0;
    repeat (10) @(negedge clk);
    chk("midrst_no_done", d_cnt, c0);
    dread(1'b0, 32'h200, 3'd4, 1'b0, 32'hDEAD_BEEF, t);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Memory controller directly downstream of the data cache and the instruction cache.
- Converts their word/halfword/byte read requests and the data cache's byte-serial write stream into accesses on the single byte-wide RAM/IO port.
- Arbitrates three requesters: data-cache write byte, data-cache read, instruction-cache read.
- Performs sign/zero extension of read results.

Parameters:
ADDR_W, 32, address width of all address ports
IO_SEL_HI, 17, upper bit of the IO select field; IO space is addr[IO_SEL_HI:IO_SEL_HI-1]==2'b11

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
d_read_i  input  1  data-cache read request; held until accepted
d_sign_i  input  1  sign-extend result (len 1/2 only)
d_len_i  input  3  bytes to read: 1, 2 or 4
d_addr_i  input  ADDR_W  data read byte address
d_data_o  output  32  data read result
d_done_o  output  1  one-cycle pulse: d_data_o valid
d_wait_o  output  1  data read cannot be accepted this cycle
d_write_i  input  1  data-cache write byte request
d_waddr_i  input  ADDR_W  write byte address
d_wdata_i  input  8  write byte
d_wwait_o  output  1  write byte cannot be accepted this cycle
d_writting_o  output  1  write byte accepted this cycle
i_read_i  input  1  instruction fetch request (always 4 bytes, zero-extended); held until accepted
i_addr_i  input  ADDR_W  fetch address
i_data_o  output  32  fetched word
i_done_o  output  1  one-cycle pulse: i_data_o valid
i_wait_o  output  1  fetch cannot be accepted this cycle
mem_din_i  input  8  RAM/IO read byte
mem_dout_o  output  8  RAM/IO write byte
mem_a_o  output  ADDR_W  RAM/IO byte address
mem_wr_o  output  1  1 = write, 0 = read
io_buffer_full_i  input  1  UART output buffer full

Behaviour:
- Reset (asynchronous): state IDLE; all counters cleared; all outputs 0.
  - mem_a_o=0, mem_wr_o=0, mem_dout_o=0.
  - d_done_o=0, i_done_o=0, d_data_o=0, i_data_o=0.
- RAM timing: byte for the address presented in cycle c appears on mem_din_i in cycle c+1. A write takes effect on the edge ending the cycle it is presented.
- FSM states: IDLE, READ.
- Acceptance (combinational, IDLE only; in READ all three wait outputs are 1). Priority order:
  1. Write byte.
     - d_wwait_o = (state!=IDLE) || (io(d_waddr_i) && io_buffer_full_i).
     - d_writting_o = d_write_i && !d_wwait_o.
  2. Data read.
     - d_wait_o = (state!=IDLE) || d_writting_o.
  3. Fetch.
     - i_wait_o = (state!=IDLE) || d_writting_o || d_read_i.
- Accepted write (cycle T): at edge T, mem_a_o<=d_waddr_i, mem_dout_o<=d_wdata_i, mem_wr_o<=1. State stays IDLE, so back-to-back bytes stream one per cycle.
- Cycles with no write acceptance: mem_wr_o<=0.
- Accepted read (cycle T):
  - At edge T latch owner (D/I), base address, len (I forces 4), sign (I forces 0); set issue count k=0 and recv count r=0; go to READ.
  - Cycles T+1..T+len: mem_a_o=base+k, mem_wr_o=0; k increments each cycle up to len, then holds the last address.
  - Cycles T+2..T+len+1: mem_din_i stored into byte lane r, little-endian; r increments.
  - Edge ending cycle T+len+1: owner's data output <= assembled, extended value; owner's done <= 1; state <= IDLE.
  - Done is high in cycle T+len+2 only. Read latency from acceptance to done = len+2 cycles (3/4/6).
  - A new request may be accepted in the done cycle.
- Extension:
  - len 1: bits [31:8] = sign ? byte0[7] : 0.
  - len 2: bits [31:16] = sign ? byte1[7] : 0.
  - len 4: raw word.
- Data outputs hold their value until the next completion for the same owner.
- Illegal len (not 1/2/4) is treated as 4.
- Address arithmetic wraps modulo 2^ADDR_W.
- IO reads use the same byte sequence. Outstanding UART writes stall only writes, never reads.
- Simultaneous d_write_i, d_read_i and i_read_i in IDLE: the write is served; both reads see wait=1.
- Reset mid-read: aborts the read, no done pulse, state IDLE.

Test Plan:
- Fetch: RAM[0x100..0x103]=13,05,00,00; i_read_i at 0x100 -> i_done_o exactly 6 cycles after acceptance, i_data_o=0x00000513, d_done_o=0.
- Signed byte read: RAM[0x20]=0x80, d_len=1, sign=1 -> d_data_o=0xFFFFFF80 at cycle 3; same with sign=0 -> 0x00000080.
- Halfword read: RAM[0x41..0x42]=0x34,0xF2, sign=1 -> 0xFFFFF234, done at cycle 4; mem_a_o sequence 0x41,0x42.
- Arbitration: d_write_i, d_read_i, i_read_i all high in one IDLE cycle -> d_writting_o=1, d_wait_o=1, i_wait_o=1. Next cycle the data read is accepted; the fetch is accepted only after d_done_o.
- 4-byte write stream to 0x30000 while io_buffer_full_i=1 for 3 cycles -> d_writting_o=0 and mem_wr_o=0 during the stall, then 4 consecutive writes with mem_a_o=0x30000..0x30003.
- rst asserted in cycle 2 of a word read -> outputs 0 asynchronously, no d_done_o; a new read after release completes normally.
